// File: rtl/seg_display_scanner_if.sv
// Bus bundle for the seven-segment scanner: digit data and load toward the
// scanner, anode/cathode drive and frame pulse back from it.
interface seg_display_scanner_if #(
   parameter int NUM_DIGITS = 4
);
   logic [7*NUM_DIGITS-1:0] seg_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blank_in;
   logic [NUM_DIGITS-1:0]   blink_in;
   logic                    load;
   logic [NUM_DIGITS-1:0]   an;
   logic [6:0]              seg;
   logic                    dp;
   logic                    frame_done;

   modport master (
      output seg_in, dp_in, blank_in, blink_in, load,
      input  an, seg, dp, frame_done
   );

   modport slave (
      input  seg_in, dp_in, blank_in, blink_in, load,
      output an, seg, dp, frame_done
   );
endinterface

// File: rtl/seg_display_scanner.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous
// double buffering, per-slot anti-ghosting blanking and per-digit blink.
module seg_display_scanner #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seg_display_scanner_if.slave bus
);
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [CW-1:0]           cnt_reg;
   logic [IW-1:0]           idx_reg;
   logic [BW-1:0]           blink_cnt_reg;
   logic                    blink_phase_reg;

   logic [7*NUM_DIGITS-1:0] pend_seg_reg, shad_seg_reg;
   logic [NUM_DIGITS-1:0]   pend_dp_reg, shad_dp_reg;
   logic [NUM_DIGITS-1:0]   pend_blank_reg, shad_blank_reg;
   logic [NUM_DIGITS-1:0]   pend_blink_reg, shad_blink_reg;

   logic [NUM_DIGITS-1:0]   an_reg, an_next;
   logic [6:0]              seg_reg, seg_next;
   logic                    dp_reg, dp_next;
   logic                    frame_done_reg;

   logic                    tick;
   logic                    boundary;
   logic [6:0]              digit_seg [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   digit_dark;

   assign tick     = (cnt_reg == CW'(REFRESH_DIV - 1));
   assign boundary = tick && (idx_reg == IW'(NUM_DIGITS - 1));

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign digit_seg[gi]  = shad_seg_reg[7*gi +: 7];
         assign digit_dark[gi] = shad_blank_reg[gi] |
                                 (shad_blink_reg[gi] & blink_phase_reg);
      end
   endgenerate

   // Everything is decoded from the current cnt/idx and registered, so the
   // pins lag the scan position by one cycle.
   always_comb begin
      an_next  = '1;
      seg_next = 7'b1111111;
      dp_next  = 1'b1;
      if ((cnt_reg >= CW'(BLANK_CYCLES)) && !digit_dark[idx_reg]) begin
         an_next  = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_reg);
         seg_next = digit_seg[idx_reg];
         dp_next  = ~shad_dp_reg[idx_reg];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg         <= '0;
         idx_reg         <= '0;
         blink_cnt_reg   <= '0;
         blink_phase_reg <= 1'b0;
         pend_seg_reg    <= '1;
         pend_dp_reg     <= '0;
         pend_blank_reg  <= '1;
         pend_blink_reg  <= '0;
         shad_seg_reg    <= '1;
         shad_dp_reg     <= '0;
         shad_blank_reg  <= '1;
         shad_blink_reg  <= '0;
         an_reg          <= '1;
         seg_reg         <= 7'b1111111;
         dp_reg          <= 1'b1;
         frame_done_reg  <= 1'b0;
      end else begin
         an_reg         <= an_next;
         seg_reg        <= seg_next;
         dp_reg         <= dp_next;
         frame_done_reg <= boundary;

         if (tick) begin
            cnt_reg <= '0;
            idx_reg <= (idx_reg == IW'(NUM_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end

         if (bus.load) begin
            pend_seg_reg   <= bus.seg_in;
            pend_dp_reg    <= bus.dp_in;
            pend_blank_reg <= bus.blank_in;
            pend_blink_reg <= bus.blink_in;
         end

         // A load landing on the boundary bypasses pending so it is not lost
         // for a whole frame.
         if (boundary) begin
            shad_seg_reg   <= bus.load ? bus.seg_in   : pend_seg_reg;
            shad_dp_reg    <= bus.load ? bus.dp_in    : pend_dp_reg;
            shad_blank_reg <= bus.load ? bus.blank_in : pend_blank_reg;
            shad_blink_reg <= bus.load ? bus.blink_in : pend_blink_reg;
            if (blink_cnt_reg == BW'(BLINK_FRAMES - 1)) begin
               blink_cnt_reg   <= '0;
               blink_phase_reg <= ~blink_phase_reg;
            end else begin
               blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
         end
      end
   end

   assign bus.an         = an_reg;
   assign bus.seg        = seg_reg;
   assign bus.dp         = dp_reg;
   assign bus.frame_done = frame_done_reg;
endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Time-multiplexed driver for the 4-digit common-anode seven-segment display.
- Consumes the 7-bit active-low segment codes produced by the binary-to-segment decoders, one per digit.
- Drives the shared cathode bus (seg, dp) and the per-digit anode enables.
- Adds frame-synchronous double-buffered loading, anti-ghosting blanking and per-digit blink for the lock's entry and alarm displays.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (2..8).
- REFRESH_DIV, 50000: clock cycles per digit slot.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off. Must be less than REFRESH_DIV.
- BLINK_FRAMES, 64: full frames per blink half-period.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- seg_in  in  7*NUM_DIGITS  segment codes; digit k occupies bits [7k+6:7k]. Bit 6=a ... bit 0=g, 0=lit.
- dp_in  in  NUM_DIGITS  decimal points, 1=lit.
- blank_in  in  NUM_DIGITS  1=digit forced dark.
- blink_in  in  NUM_DIGITS  1=digit blinks.
- load  in  1  capture seg_in/dp_in/blank_in/blink_in into the pending buffer.
- an  out  NUM_DIGITS  anode enables, active-low.
- seg  out  7  cathodes, active-low, same bit order as seg_in.
- dp  out  1  decimal-point cathode, active-low.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (rst_n=0 at a clk edge), all synchronous:
  - an = all 1s, seg = 7'b1111111, dp = 1, frame_done = 0.
  - Prescaler cnt = 0, digit index idx = 0, blink counter = 0, blink_phase = 0.
  - Pending and shadow buffers are cleared to segments 7'b1111111, dp 0, blank 1, blink 0, so the display is dark.
  - Reset takes priority over every other input, including mid-slot and mid-frame.
- Prescaler: cnt counts 0..REFRESH_DIV-1 and wraps to 0. The terminal count is "tick".
- On tick: idx increments and wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the tick with idx=NUM_DIGITS-1.
  - frame_done is asserted for exactly the following cycle.
  - Shadow is loaded from pending.
  - The blink counter increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- Load handling:
  - load=1 copies all four input buses into pending.
  - Pending is never visible on the outputs until a frame boundary, so there is no tearing within a frame.
  - If load coincides with a frame boundary, the load data goes straight to shadow and to pending.
  - Multiple loads within one frame: the last one wins.
  - After reset, nothing is shown until the first boundary following a load.
- Outputs are registered, with a 1-cycle latency from (cnt, idx).
- Digit i is dark when any of the following holds:
  - cnt < BLANK_CYCLES, or
  - shadow blank[i] = 1, or
  - shadow blink[i] = 1 and blink_phase = 1.
- When dark: an = all 1s, seg = 7'b1111111, dp = 1.
- Otherwise: an = all 1s except bit i = 0, seg = shadow segment code for digit i, dp = ~shadow dp[i].
- At most one an bit is low in any cycle, under all conditions.
- Width rules:
  - cnt is sized as clog2(REFRESH_DIV).
  - idx is sized as clog2(NUM_DIGITS); it wraps by explicit compare, not by overflow, so NUM_DIGITS need not be a power of 2.
  - The blink counter is sized as clog2(BLINK_FRAMES).
- Input encodings: any 7-bit seg_in pattern is passed through unchanged, including undefined decoder codes; no decoding is done in this block.

Test Plan:
Bench parameters: REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2, NUM_DIGITS=4.
- Reset: hold rst_n=0 for 3 cycles with load=1 -> an=4'b1111, seg=7'b1111111, dp=1, frame_done=0. After release, the display stays dark for the first 32-cycle frame.
- Basic scan:
  - Stimulus: load once with digits 3..0 = 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001 and dp_in=4'b0001.
  - After the next boundary, each 8-cycle slot shows 2 cycles of an=1111 followed by 6 cycles of the digit's an (1110, 1101, 1011, 0111 in order).
  - seg matches each digit; dp=0 only during digit 0.
  - frame_done pulses every 32 cycles.
- No tearing: pulse load with new data while idx=1 -> the outputs keep the old codes until the frame_done pulse, then switch on digit 0 of the next frame.
- Coincident load: assert load on the boundary cycle -> the new data is visible on the very next digit-0 slot.
- Blink: blink_in=4'b0100 -> digit 2 is lit for 2 frames, dark for 2 frames, repeating. The other digits are unaffected; blank_in=4'b1000 keeps digit 3 dark throughout.
- Reset mid-slot: drop rst_n during idx=2, cnt=5 -> the next cycle shows an=1111 and cnt=0, idx=0; shadow is cleared, so the display is dark until the next load and boundary.
